// File: rtl/rggen_axi4lite_pkg.sv
// Shared encodings for the AXI4-Lite pipelined adapter: bus access codes,
// response codes, arbitration modes and the grant-lock FSM states.
package rggen_axi4lite_pkg;

    localparam logic [1:0] ACCESS_WRITE = 2'b11;
    localparam logic [1:0] ACCESS_READ  = 2'b10;

    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;

    typedef enum logic [1:0] {
        ARB_WRITE_FIRST = 2'd0,
        ARB_READ_FIRST  = 2'd1,
        ARB_ROUND_ROBIN = 2'd2
    } arb_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOCK_WRITE,
        ST_LOCK_READ
    } lock_state_e;

endpackage

// File: rtl/rggen_resp_fifo.sv
// Response queue: DEPTH-entry FIFO with modulo-DEPTH pointers. A push is
// accepted while full when a pop happens in the same cycle.
module rggen_resp_fifo
    import rggen_axi4lite_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
)(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by r_count alone.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/rggen_axi4lite_pipelined_adapter.sv
// AXI4-Lite to rggen bus adapter with per-channel response queues and
// zero-latency issue. Optional prot filtering: RGGEN_AXI4LITE_PROT_CHECK_EN.
module rggen_axi4lite_pipelined_adapter
    import rggen_axi4lite_pkg::*;
#(
    parameter int         ID_WIDTH      = 0,
    parameter int         ADDRESS_WIDTH = 8,
    parameter int         BUS_WIDTH     = 32,
    parameter int         RESP_DEPTH    = 2,
    parameter int         ARB_MODE      = 0,
    parameter logic [2:0] PROT_MASK     = 3'b000
)(
    input  logic                                      i_clk,
    input  logic                                      i_rst,
    input  logic                                      i_awvalid,
    output logic                                      o_awready,
    input  logic [((ID_WIDTH > 0) ? ID_WIDTH : 1)-1:0] i_awid,
    input  logic [ADDRESS_WIDTH-1:0]                  i_awaddr,
    input  logic [2:0]                                i_awprot,
    input  logic                                      i_wvalid,
    output logic                                      o_wready,
    input  logic [BUS_WIDTH-1:0]                      i_wdata,
    input  logic [BUS_WIDTH/8-1:0]                    i_wstrb,
    output logic                                      o_bvalid,
    input  logic                                      i_bready,
    output logic [((ID_WIDTH > 0) ? ID_WIDTH : 1)-1:0] o_bid,
    output logic [1:0]                                o_bresp,
    input  logic                                      i_arvalid,
    output logic                                      o_arready,
    input  logic [((ID_WIDTH > 0) ? ID_WIDTH : 1)-1:0] i_arid,
    input  logic [ADDRESS_WIDTH-1:0]                  i_araddr,
    input  logic [2:0]                                i_arprot,
    output logic                                      o_rvalid,
    input  logic                                      i_rready,
    output logic [((ID_WIDTH > 0) ? ID_WIDTH : 1)-1:0] o_rid,
    output logic [1:0]                                o_rresp,
    output logic [BUS_WIDTH-1:0]                      o_rdata,
    output logic                                      o_bus_valid,
    output logic [1:0]                                o_bus_access,
    output logic [ADDRESS_WIDTH-1:0]                  o_bus_address,
    output logic [BUS_WIDTH-1:0]                      o_bus_write_data,
    output logic [BUS_WIDTH/8-1:0]                    o_bus_strobe,
    input  logic                                      i_bus_ready,
    input  logic [1:0]                                i_bus_status,
    input  logic [BUS_WIDTH-1:0]                      i_bus_read_data
);

    localparam int        IW    = (ID_WIDTH > 0) ? ID_WIDTH : 1;
    localparam arb_mode_e L_ARB = arb_mode_e'(ARB_MODE[1:0]);

    lock_state_e          r_state;
    lock_state_e          w_state_next;
    logic                 r_rr_read_next;
    logic                 w_grant_write;
    logic                 w_grant_read;
    logic                 w_bus_valid;
    logic                 w_wr_accept;
    logic                 w_rd_accept;
    logic                 w_wr_err;
    logic                 w_rd_err;
    logic                 w_wr_req;
    logic                 w_rd_req;
    logic                 w_wq_full;
    logic                 w_wq_empty;
    logic                 w_rq_full;
    logic                 w_rq_empty;
    logic [IW-1:0]        w_awid;
    logic [IW-1:0]        w_arid;
    logic [IW+1:0]        w_wq_data;
    logic [IW+BUS_WIDTH+1:0] w_rq_data;

`ifdef RGGEN_AXI4LITE_PROT_CHECK_EN
    assign w_wr_err = |(i_awprot & PROT_MASK);
    assign w_rd_err = |(i_arprot & PROT_MASK);
`else
    logic w_unused_prot;
    assign w_unused_prot = ^{i_awprot, i_arprot, PROT_MASK};
    assign w_wr_err = 1'b0;
    assign w_rd_err = 1'b0;
`endif

    // A full queue still has room when its head pops this cycle.
    assign w_wr_req = i_awvalid && i_wvalid && (!w_wq_full || i_bready);
    assign w_rd_req = i_arvalid && (!w_rq_full || i_rready);

    always_comb begin
        w_state_next  = ST_IDLE;
        w_grant_write = 1'b0;
        w_grant_read  = 1'b0;
        if (!i_rst) begin
            case (r_state)
                ST_LOCK_WRITE: w_grant_write = 1'b1;
                ST_LOCK_READ:  w_grant_read  = 1'b1;
                default: begin
                    if (w_wr_req && w_rd_req) begin
                        case (L_ARB)
                            ARB_READ_FIRST:  w_grant_read = 1'b1;
                            ARB_ROUND_ROBIN: begin
                                w_grant_read  = r_rr_read_next;
                                w_grant_write = !r_rr_read_next;
                            end
                            default:         w_grant_write = 1'b1;
                        endcase
                    end else begin
                        w_grant_write = w_wr_req;
                        w_grant_read  = w_rd_req;
                    end
                end
            endcase
        end
        w_bus_valid = (w_grant_write && !w_wr_err) || (w_grant_read && !w_rd_err);
        w_wr_accept = w_grant_write && (w_wr_err || i_bus_ready);
        w_rd_accept = w_grant_read  && (w_rd_err || i_bus_ready);
        if (w_bus_valid && !i_bus_ready) begin
            w_state_next = w_grant_write ? ST_LOCK_WRITE : ST_LOCK_READ;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_rr_read_next <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_wr_accept)      r_rr_read_next <= 1'b1;
            else if (w_rd_accept) r_rr_read_next <= 1'b0;
        end
    end

    assign o_bus_valid      = w_bus_valid;
    assign o_bus_access     = w_grant_read ? ACCESS_READ : ACCESS_WRITE;
    assign o_bus_address    = w_grant_read ? i_araddr : i_awaddr;
    assign o_bus_write_data = i_wdata;
    assign o_bus_strobe     = w_grant_read ? '0 : i_wstrb;
    assign o_awready        = w_wr_accept;
    assign o_wready         = w_wr_accept;
    assign o_arready        = w_rd_accept;

    assign w_awid = (ID_WIDTH > 0) ? i_awid : '0;
    assign w_arid = (ID_WIDTH > 0) ? i_arid : '0;

    rggen_resp_fifo #(
        .WIDTH (IW + 2),
        .DEPTH (RESP_DEPTH)
    ) u_write_queue (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_wr_accept),
        .i_data  ({w_awid, (w_wr_err ? RESP_SLVERR : i_bus_status)}),
        .i_pop   (i_bready),
        .o_data  (w_wq_data),
        .o_full  (w_wq_full),
        .o_empty (w_wq_empty)
    );

    rggen_resp_fifo #(
        .WIDTH (IW + BUS_WIDTH + 2),
        .DEPTH (RESP_DEPTH)
    ) u_read_queue (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_rd_accept),
        .i_data  ({w_arid, (w_rd_err ? RESP_SLVERR : i_bus_status),
                   (w_rd_err ? {BUS_WIDTH{1'b0}} : i_bus_read_data)}),
        .i_pop   (i_rready),
        .o_data  (w_rq_data),
        .o_full  (w_rq_full),
        .o_empty (w_rq_empty)
    );

    assign o_bvalid           = !w_wq_empty;
    assign {o_bid, o_bresp}   = w_wq_data;
    assign o_rvalid           = !w_rq_empty;
    assign {o_rid, o_rresp, o_rdata} = w_rq_data;

endmodule

// File: tb/tb_rggen_axi4lite_pipelined_adapter.sv
// Scoreboard bench for rggen_axi4lite_pipelined_adapter (round-robin, depth 2,
// 4-bit IDs). Prot scenario runs when RGGEN_AXI4LITE_PROT_CHECK_EN is defined.
module tb_rggen_axi4lite_pipelined_adapter;

    typedef struct packed {
        logic [3:0]  id;
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [3:0]  awid, arid, bid, rid, wstrb, bus_strobe;
    logic [7:0]  awaddr, araddr, bus_address;
    logic [2:0]  awprot, arprot;
    logic [31:0] wdata, rdata, bus_wdata, bus_rdata;
    logic [1:0]  bresp, rresp, bus_access, bus_status;
    logic        bus_valid, bus_ready;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_b[$];
    exp_t exp_r[$];

    always #5 clk = ~clk;

    rggen_axi4lite_pipelined_adapter #(
        .ID_WIDTH      (4),
        .ADDRESS_WIDTH (8),
        .BUS_WIDTH     (32),
        .RESP_DEPTH    (2),
        .ARB_MODE      (2),
        .PROT_MASK     (3'b010)
    ) dut (
        .i_clk (clk), .i_rst (rst),
        .i_awvalid (awvalid), .o_awready (awready), .i_awid (awid),
        .i_awaddr (awaddr), .i_awprot (awprot),
        .i_wvalid (wvalid), .o_wready (wready), .i_wdata (wdata), .i_wstrb (wstrb),
        .o_bvalid (bvalid), .i_bready (bready), .o_bid (bid), .o_bresp (bresp),
        .i_arvalid (arvalid), .o_arready (arready), .i_arid (arid),
        .i_araddr (araddr), .i_arprot (arprot),
        .o_rvalid (rvalid), .i_rready (rready), .o_rid (rid), .o_rresp (rresp),
        .o_rdata (rdata),
        .o_bus_valid (bus_valid), .o_bus_access (bus_access),
        .o_bus_address (bus_address), .o_bus_write_data (bus_wdata),
        .o_bus_strobe (bus_strobe), .i_bus_ready (bus_ready),
        .i_bus_status (bus_status), .i_bus_read_data (bus_rdata)
    );

    task automatic idle_inputs();
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
        awid = 0; arid = 0; awaddr = 0; araddr = 0; awprot = 0; arprot = 0;
        wdata = 0; wstrb = 4'hF; bus_ready = 0; bus_status = 0; bus_rdata = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1; idle_inputs();
        step(); step();
        rst = 0;
        exp_b.delete(); exp_r.delete();
    endtask

    task automatic push_b(input logic [3:0] id, input logic [1:0] resp);
        exp_t e;
        e.id = id; e.resp = resp; e.data = '0;
        exp_b.push_back(e);
    endtask

    task automatic push_r(input logic [3:0] id, input logic [1:0] resp, input logic [31:0] d);
        exp_t e;
        e.id = id; e.resp = resp; e.data = d;
        exp_r.push_back(e);
    endtask

    task automatic drain(input int max_cycles);
        exp_t e;
        bready = 1; rready = 1;
        for (int c = 0; c < max_cycles && (exp_b.size() > 0 || exp_r.size() > 0); c++) begin
            @(negedge clk);
            if (bvalid) begin
                n_checks++;
                if (exp_b.size() == 0) begin
                    n_fail++; $display("FAIL b_unexpected: got id=%h resp=%b required no response", bid, bresp);
                end else begin
                    e = exp_b.pop_front();
                    if ({bid, bresp} !== {e.id, e.resp}) begin
                        n_fail++; $display("FAIL b_order: got id=%h resp=%b required id=%h resp=%b", bid, bresp, e.id, e.resp);
                    end
                end
            end
            if (rvalid) begin
                n_checks++;
                if (exp_r.size() == 0) begin
                    n_fail++; $display("FAIL r_unexpected: got id=%h resp=%b data=%h required no response", rid, rresp, rdata);
                end else begin
                    e = exp_r.pop_front();
                    if ({rid, rresp, rdata} !== {e.id, e.resp, e.data}) begin
                        n_fail++; $display("FAIL r_order: got id=%h resp=%b data=%h required id=%h resp=%b data=%h",
                                           rid, rresp, rdata, e.id, e.resp, e.data);
                    end
                end
            end
            step();
        end
        n_checks++;
        if (exp_b.size() != 0 || exp_r.size() != 0) begin
            n_fail++; $display("FAIL drain_timeout: got %0d/%0d responses outstanding required 0/0", exp_b.size(), exp_r.size());
            exp_b.delete(); exp_r.delete();
        end
        bready = 0; rready = 0;
        @(negedge clk);
        n_checks++;
        if ({bvalid, rvalid} !== 2'b00) begin
            n_fail++; $display("FAIL drain_empty: got bvalid/rvalid=%b required 00", {bvalid, rvalid});
        end
        step();
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs();
        awvalid = 1; wvalid = 1; arvalid = 1; bus_ready = 1; bready = 1; rready = 1;
        step();
        @(negedge clk);
        n_checks++;
        if ({bvalid, rvalid, bus_valid, awready, wready, arready} !== 6'b0) begin
            n_fail++; $display("FAIL reset_hold: got %b required 000000", {bvalid, rvalid, bus_valid, awready, wready, arready});
        end
        step();
        idle_inputs(); rst = 0;
        @(negedge clk);
        n_checks++;
        if ({bvalid, rvalid, bus_valid, awready, arready} !== 5'b0) begin
            n_fail++; $display("FAIL reset_release: got %b required 00000", {bvalid, rvalid, bus_valid, awready, arready});
        end
        step();
    endtask

    task automatic test_round_robin();
        logic exp_write;
        bus_ready = 1; awvalid = 1; wvalid = 1; arvalid = 1;
        for (int k = 0; k < 4; k++) begin
            awid = 4'(k); arid = 4'(k + 8);
            awaddr = 8'h40 + 8'(k * 4); araddr = 8'h80 + 8'(k * 4);
            wdata = 32'hD000_0000 | 32'(k); bus_status = 2'(k);
            bus_rdata = 32'hC0DE_0000 | 32'(k);
            exp_write = (k % 2 == 0);
            @(negedge clk);
            n_checks++;
            if ({awready, wready, arready} !== (exp_write ? 3'b110 : 3'b001)) begin
                n_fail++; $display("FAIL rr_grant round %0d: got aw/w/ar ready=%b required %b", k,
                                   {awready, wready, arready}, exp_write ? 3'b110 : 3'b001);
            end
            n_checks++;
            if ({bus_valid, bus_access, bus_address} !== {1'b1, (exp_write ? 2'b11 : 2'b10), (exp_write ? awaddr : araddr)}) begin
                n_fail++; $display("FAIL rr_bus round %0d: got valid=%b access=%b addr=%h", k, bus_valid, bus_access, bus_address);
            end
            if (exp_write) push_b(awid, bus_status);
            else           push_r(arid, bus_status, bus_rdata);
            step();
        end
        @(negedge clk);
        n_checks++;
        if ({bus_valid, awready, arready, bvalid, rvalid} !== 5'b00011) begin
            n_fail++; $display("FAIL rr_full: got valid/awr/arr/bv/rv=%b required 00011", {bus_valid, awready, arready, bvalid, rvalid});
        end
        step();
        awvalid = 0; wvalid = 0; arvalid = 0;
        drain(20);
    endtask

    task automatic test_single_write();
        exp_t e;
        awvalid = 1; wvalid = 1; awid = 4'h3; awaddr = 8'h10; wdata = 32'hA5A5A5A5;
        wstrb = 4'hF; bus_ready = 1; bus_status = 2'b00;
        @(negedge clk);
        n_checks++;
        if ({awready, wready, bus_valid, bus_access, bus_address, bus_wdata, bus_strobe, bvalid} !==
            {1'b1, 1'b1, 1'b1, 2'b11, 8'h10, 32'hA5A5A5A5, 4'hF, 1'b0}) begin
            n_fail++; $display("FAIL single_issue: got aw/w=%b%b valid=%b acc=%b addr=%h data=%h strb=%h bvalid=%b",
                               awready, wready, bus_valid, bus_access, bus_address, bus_wdata, bus_strobe, bvalid);
        end
        push_b(awid, bus_status);
        step();
        awvalid = 0; wvalid = 0; bready = 1;
        @(negedge clk);
        e = exp_b.pop_front();
        n_checks++;
        if ({bvalid, bid, bresp} !== {1'b1, e.id, e.resp}) begin
            n_fail++; $display("FAIL single_bresp: got bvalid=%b id=%h resp=%b required 1 id=%h resp=%b", bvalid, bid, bresp, e.id, e.resp);
        end
        step();
        bready = 0;
        @(negedge clk);
        n_checks++;
        if (bvalid !== 1'b0) begin
            n_fail++; $display("FAIL single_pop: got bvalid=%b required 0", bvalid);
        end
        step();
    endtask

    task automatic test_queue_full();
        exp_t e;
        bus_ready = 1; bready = 0; awvalid = 1; wvalid = 1; bus_status = 2'b00;
        for (int k = 1; k <= 2; k++) begin
            awid = 4'(k); awaddr = 8'(k * 8);
            @(negedge clk);
            n_checks++;
            if (awready !== 1'b1) begin
                n_fail++; $display("FAIL full_fill %0d: got awready=%b required 1", k, awready);
            end
            push_b(awid, bus_status);
            step();
        end
        awid = 4'h3; awaddr = 8'h18;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++;
            if ({awready, wready, bus_valid} !== 3'b000) begin
                n_fail++; $display("FAIL full_block %0d: got aw/w/valid=%b required 000", k, {awready, wready, bus_valid});
            end
            step();
        end
        bready = 1;
        @(negedge clk);
        e = exp_b.pop_front();
        n_checks++;
        if ({bvalid, bid, awready, bus_valid} !== {1'b1, e.id, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL full_pop_issue: got bvalid=%b bid=%h awready=%b valid=%b required 1 %h 1 1",
                               bvalid, bid, awready, bus_valid, e.id);
        end
        push_b(awid, bus_status);
        step();
        awvalid = 0; wvalid = 0;
        drain(20);
    endtask

    task automatic test_bus_stall();
        awvalid = 1; wvalid = 1; awid = 4'h5; awaddr = 8'h24; wdata = 32'h1234ABCD;
        wstrb = 4'h6; bus_ready = 0; bus_status = 2'b00;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin arvalid = 1; arid = 4'h6; araddr = 8'h30; end
            if (c == 3) bus_ready = 1;
            @(negedge clk);
            n_checks++;
            if ({bus_valid, bus_access, bus_address, bus_wdata, bus_strobe} !== {1'b1, 2'b11, 8'h24, 32'h1234ABCD, 4'h6}) begin
                n_fail++; $display("FAIL stall_stable cycle %0d: got valid=%b acc=%b addr=%h data=%h strb=%h",
                                   c, bus_valid, bus_access, bus_address, bus_wdata, bus_strobe);
            end
            n_checks++;
            if ({awready, arready} !== {(c == 3), 1'b0}) begin
                n_fail++; $display("FAIL stall_ready cycle %0d: got aw/ar=%b required %b", c, {awready, arready}, {(c == 3), 1'b0});
            end
            step();
        end
        push_b(4'h5, 2'b00);
        awvalid = 0; wvalid = 0; bus_rdata = 32'hFEEDF00D; bus_status = 2'b10;
        @(negedge clk);
        n_checks++;
        if ({arready, bus_access, bus_address} !== {1'b1, 2'b10, 8'h30}) begin
            n_fail++; $display("FAIL stall_read_after: got arready=%b acc=%b addr=%h required 1 10 30", arready, bus_access, bus_address);
        end
        push_r(4'h6, 2'b10, 32'hFEEDF00D);
        step();
        arvalid = 0;
        drain(20);
    endtask

    task automatic test_reset_mid();
        arvalid = 1; arid = 4'h7; araddr = 8'h40; bus_ready = 1; bus_rdata = 32'hAAAA5555;
        step();
        arid = 4'h8; araddr = 8'h44; bus_ready = 0;
        @(negedge clk);
        n_checks++;
        if ({bus_valid, arready, rvalid} !== 3'b101) begin
            n_fail++; $display("FAIL midrst_lock: got valid/arready/rvalid=%b required 101", {bus_valid, arready, rvalid});
        end
        step();
        rst = 1; arvalid = 0;
        step();
        @(negedge clk);
        n_checks++;
        if ({rvalid, bus_valid, arready} !== 3'b000) begin
            n_fail++; $display("FAIL midrst_clear: got rvalid/valid/arready=%b required 000", {rvalid, bus_valid, arready});
        end
        step();
        rst = 0;
        @(negedge clk);
        n_checks++;
        if ({rvalid, bus_valid} !== 2'b00) begin
            n_fail++; $display("FAIL midrst_release: got rvalid/valid=%b required 00", {rvalid, bus_valid});
        end
        step();
        arvalid = 1; arid = 4'h9; araddr = 8'h48; bus_ready = 1; bus_status = 2'b00;
        bus_rdata = 32'h12345678;
        @(negedge clk);
        n_checks++;
        if ({arready, bus_valid} !== 2'b11) begin
            n_fail++; $display("FAIL midrst_fresh: got arready/valid=%b required 11", {arready, bus_valid});
        end
        push_r(4'h9, 2'b00, 32'h12345678);
        step();
        arvalid = 0;
        drain(20);
    endtask

`ifdef RGGEN_AXI4LITE_PROT_CHECK_EN
    task automatic test_prot();
        arvalid = 1; arid = 4'hA; araddr = 8'h50; arprot = 3'b010; bus_ready = 0;
        bus_rdata = 32'hDEADBEEF; bus_status = 2'b00;
        @(negedge clk);
        n_checks++;
        if ({bus_valid, arready} !== 2'b01) begin
            n_fail++; $display("FAIL prot_filter: got valid/arready=%b required 01", {bus_valid, arready});
        end
        push_r(4'hA, 2'b10, 32'h0);
        step();
        arvalid = 0; arprot = 3'b000;
        drain(20);
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_round_robin();
        do_reset();
        test_single_write();
        test_queue_full();
        test_bus_stall();
        test_reset_mid();
`ifdef RGGEN_AXI4LITE_PROT_CHECK_EN
        test_prot();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
